// File: rtl/time_count_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : time_count_ctrl_if
// Description : Bundle between the time-setting FSM (master) and the
//               HH:MM:SS time-count controller (slave).
//               master drives : secs, hours_inc, mins_inc
//               slave drives  : sec_ones, sec_tens, min_ones, min_tens,
//                               hour_ones, hour_tens, tick, day_wrap, mode
// Revision    : 1.0 - initial release
// ============================================================================
interface time_count_ctrl_if;
  logic       secs;       // 1 = run, 0 = set mode
  logic       hours_inc;  // hour increment request (pulse or level)
  logic       mins_inc;   // minute increment request (pulse or level)
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic [3:0] hour_ones;
  logic [1:0] hour_tens;
  logic       tick;       // 1 s pulse
  logic       day_wrap;   // hours rolled over to 00 while running
  logic       mode;       // 0 = SET, 1 = RUN

  modport master (
    output secs, hours_inc, mins_inc,
    input  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
           tick, day_wrap, mode
  );

  modport slave (
    input  secs, hours_inc, mins_inc,
    output sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens,
           tick, day_wrap, mode
  );
endinterface
`default_nettype wire

// File: rtl/time_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_count_ctrl
// Description : Sequences the HH:MM:SS BCD time datapath. In RUN a prescaler
//               divides clk to a 1 s tick that drives the sec->min->hour
//               carry chain. In SET seconds are held at 00 and rising edges
//               of the hour/minute increment requests step the fields.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset
//               bus    - time_count_ctrl_if.slave (controls in, digits,
//                        tick, day_wrap and mode out)
// Revision    : 1.0 - initial release
// ============================================================================
module time_count_ctrl #(
  parameter int TICK_DIV = 1000,  // clk cycles per second, 2..2^16
  parameter int HOUR_MAX = 24     // 24 or 12
) (
  input  logic                clk,
  input  logic                reset,
  time_count_ctrl_if.slave    bus
);

  localparam int              PW             = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST     = PW'(TICK_DIV - 1);
  // Last legal hour as BCD digits: 23 for a 24 h clock, 11 for a 12 h clock.
  localparam logic [1:0]      HOUR_LAST_TENS = (HOUR_MAX == 12) ? 2'd1 : 2'd2;
  localparam logic [3:0]      HOUR_LAST_ONES = (HOUR_MAX == 12) ? 4'd1 : 4'd3;

  typedef enum logic [0:0] {
    ST_SET = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          hours_prev, mins_prev;
  logic [3:0]    sec_ones, min_ones, hour_ones;
  logic [2:0]    sec_tens, min_tens;
  logic [1:0]    hour_tens;
  logic          day_wrap;

  logic          tick;
  logic          hours_edge, mins_edge;
  logic [3:0]    sec_ones_n, min_ones_n, hour_ones_n;
  logic [2:0]    sec_tens_n, min_tens_n;
  logic [1:0]    hour_tens_n;
  logic          min_step, min_carry, hour_step, hour_wrap, day_wrap_n;

  // Tick is decoded from registered state and prescaler, so it is high for
  // exactly the cycle in which the prescaler holds its last value.
  assign tick       = (state == ST_RUN) && (presc == PRESC_LAST);
  assign hours_edge = bus.hours_inc & ~hours_prev;
  assign mins_edge  = bus.mins_inc  & ~mins_prev;

  always_comb begin
    sec_ones_n  = sec_ones;
    sec_tens_n  = sec_tens;
    min_ones_n  = min_ones;
    min_tens_n  = min_tens;
    hour_ones_n = hour_ones;
    hour_tens_n = hour_tens;
    min_step    = 1'b0;
    min_carry   = 1'b0;
    hour_step   = 1'b0;
    hour_wrap   = 1'b0;
    day_wrap_n  = 1'b0;

    if (state == ST_SET) begin
      sec_ones_n = 4'd0;
      sec_tens_n = 3'd0;
      min_step   = mins_edge;
    end else if (tick) begin
      // ">=" rather than "==" so an out-of-range digit clears on its next step
      if (sec_ones >= 4'd9) begin
        sec_ones_n = 4'd0;
        if (sec_tens >= 3'd5) begin
          sec_tens_n = 3'd0;
          min_step   = 1'b1;
        end else begin
          sec_tens_n = sec_tens + 3'd1;
        end
      end else begin
        sec_ones_n = sec_ones + 4'd1;
      end
    end

    if (min_step) begin
      if (min_ones >= 4'd9) begin
        min_ones_n = 4'd0;
        if (min_tens >= 3'd5) begin
          min_tens_n = 3'd0;
          min_carry  = 1'b1;
        end else begin
          min_tens_n = min_tens + 3'd1;
        end
      end else begin
        min_ones_n = min_ones + 4'd1;
      end
    end

    // Minute wrap only feeds hours while running; in SET the fields are
    // stepped independently.
    hour_step = (state == ST_SET) ? hours_edge : min_carry;

    if (hour_step) begin
      if ((hour_tens > HOUR_LAST_TENS) ||
          ((hour_tens == HOUR_LAST_TENS) && (hour_ones >= HOUR_LAST_ONES))) begin
        hour_ones_n = 4'd0;
        hour_tens_n = 2'd0;
        hour_wrap   = 1'b1;
      end else if (hour_ones >= 4'd9) begin
        hour_ones_n = 4'd0;
        hour_tens_n = hour_tens + 2'd1;
      end else begin
        hour_ones_n = hour_ones + 4'd1;
      end
    end

    day_wrap_n = hour_wrap && (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SET;
      presc      <= '0;
      hours_prev <= 1'b0;
      mins_prev  <= 1'b0;
      sec_ones   <= 4'd0;
      sec_tens   <= 3'd0;
      min_ones   <= 4'd0;
      min_tens   <= 3'd0;
      hour_ones  <= 4'd0;
      hour_tens  <= 2'd0;
      day_wrap   <= 1'b0;
    end else begin
      state <= bus.secs ? ST_RUN : ST_SET;

      if (state == ST_RUN) begin
        presc <= tick ? '0 : presc + PW'(1);
      end else begin
        presc <= '0;
      end

      // Edge registers track the inputs in both states so a level held
      // across RUN->SET does not fire on entry to SET.
      hours_prev <= bus.hours_inc;
      mins_prev  <= bus.mins_inc;

      sec_ones   <= sec_ones_n;
      sec_tens   <= sec_tens_n;
      min_ones   <= min_ones_n;
      min_tens   <= min_tens_n;
      hour_ones  <= hour_ones_n;
      hour_tens  <= hour_tens_n;
      day_wrap   <= day_wrap_n;
    end
  end

  assign bus.sec_ones  = sec_ones;
  assign bus.sec_tens  = sec_tens;
  assign bus.min_ones  = min_ones;
  assign bus.min_tens  = min_tens;
  assign bus.hour_ones = hour_ones;
  assign bus.hour_tens = hour_tens;
  assign bus.tick      = tick;
  assign bus.day_wrap  = day_wrap;
  assign bus.mode      = (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_time_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_count_ctrl
// Description : Self-checking bench for time_count_ctrl (TICK_DIV=4,
//               HOUR_MAX=24): a vector table for SET-mode strobe handling
//               plus directed sequences for the multi-cycle corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_count_ctrl;

  localparam int TICK_DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  time_count_ctrl_if bus ();

  time_count_ctrl #(
    .TICK_DIV (TICK_DIV),
    .HOUR_MAX (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        secs;
    logic        hi;
    logic        mi;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl [15];

  // Packed expectation: {HH, MM, SS digits, tick, day_wrap, mode}
  function automatic logic [22:0] pk(input int ht, input int ho, input int mt,
                                     input int mo, input int st, input int so,
                                     input bit t, input bit w, input bit md);
    return {ht[1:0], ho[3:0], mt[2:0], mo[3:0], st[2:0], so[3:0], t, w, md};
  endfunction

  function automatic string fmt(input logic [22:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d tick=%0b day_wrap=%0b mode=%0b",
                     v[22:21], v[20:17], v[16:14], v[13:10], v[9:7], v[6:3],
                     v[2], v[1], v[0]);
  endfunction

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] a;
    a = {bus.hour_tens, bus.hour_ones, bus.min_tens, bus.min_ones,
         bus.sec_tens, bus.sec_ones, bus.tick, bus.day_wrap, bus.mode};
    n_checks++;
    if (a === exp) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, fmt(a), fmt(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.secs = 1'b0;
    bus.hours_inc = 1'b0;
    bus.mins_inc = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse(input bit h, input bit m);
    bus.hours_inc = h;
    bus.mins_inc  = m;
    step();
    bus.hours_inc = 1'b0;
    bus.mins_inc  = 1'b0;
    step();
  endtask

  task automatic set_hm(input int h, input int m);
    for (int i = 0; i < h; i++) pulse(1'b1, 1'b0);
    for (int i = 0; i < m; i++) pulse(1'b0, 1'b1);
  endtask

  // Runs until n ticks have been seen, then one more edge so the last
  // update has landed; the prescaler is 0 on return.
  task automatic run_ticks(input int n);
    int seen;
    bit ok;
    seen = 0;
    ok   = 1'b0;
    bus.secs = 1'b1;
    for (int c = 0; c < n * TICK_DIV + 8; c++) begin
      step();
      if (bus.tick) begin
        seen++;
        if (seen == n) begin
          step();
          ok = 1'b1;
          break;
        end
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL run_ticks: saw %0d ticks, required %0d", seen, n);
  endtask

  initial begin
    bit seen_wrap;
    bit exp_tick;
    int exp_so;

    tbl[0]  = '{1'b0, 1'b1, 1'b1, pk(0,1,0,1,0,0,0,0,0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, pk(0,1,0,1,0,0,0,0,0)};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, pk(0,1,0,1,0,0,0,0,0)};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, pk(0,1,0,1,0,0,0,0,0)};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, pk(0,1,0,1,0,0,0,0,0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, pk(0,1,0,1,0,0,0,0,0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, pk(0,1,0,2,0,0,0,0,0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, pk(0,1,0,2,0,0,0,0,0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, pk(0,2,0,2,0,0,0,0,0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, pk(0,2,0,3,0,0,0,0,0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, pk(0,2,0,3,0,0,0,0,1)};
    tbl[11] = '{1'b1, 1'b1, 1'b1, pk(0,2,0,3,0,0,0,0,1)};
    tbl[12] = '{1'b0, 1'b1, 1'b1, pk(0,2,0,3,0,0,0,0,0)};
    tbl[13] = '{1'b0, 1'b1, 1'b1, pk(0,2,0,3,0,0,0,0,0)};
    tbl[14] = '{1'b0, 1'b0, 1'b0, pk(0,2,0,3,0,0,0,0,0)};

    bus.secs = 1'b0;
    bus.hours_inc = 1'b0;
    bus.mins_inc = 1'b0;

    // Reset, then 9 cycles of RUN
    do_reset();
    check("reset", pk(0,0,0,0,0,0,0,0,0));
    bus.secs = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_tick = (k == 4) || (k == 8);
      exp_so   = (k >= 9) ? 2 : ((k >= 5) ? 1 : 0);
      check($sformatf("run_cycle%0d", k), pk(0,0,0,0,0,exp_so,exp_tick,0,1));
    end
    bus.secs = 1'b0;
    step();
    check("run_to_set_mode", pk(0,0,0,0,0,2,0,0,0));
    step();
    check("set_clears_secs", pk(0,0,0,0,0,0,0,0,0));

    // SET-mode strobe vectors
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.secs      = tbl[i].secs;
      bus.hours_inc = tbl[i].hi;
      bus.mins_inc  = tbl[i].mi;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // 60 minute pulses in SET: wraps without touching hours
    do_reset();
    seen_wrap = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.mins_inc = 1'b1;
      step();
      seen_wrap |= bus.day_wrap;
      bus.mins_inc = 1'b0;
      step();
      seen_wrap |= bus.day_wrap;
      if (i == 29) check("mins_30", pk(0,0,3,0,0,0,0,0,0));
    end
    check("mins_60_wrap", pk(0,0,0,0,0,0,0,0,0));
    n_checks++;
    if (!seen_wrap) n_pass++;
    else $display("FAIL set_min_no_day_wrap: got day_wrap pulse, expected none");

    // 23:59:58 -> 00:00:00 with day_wrap
    do_reset();
    set_hm(23, 59);
    check("preload_2359", pk(2,3,5,9,0,0,0,0,0));
    run_ticks(58);
    check("at_235958", pk(2,3,5,9,5,8,0,0,1));
    step(); step(); step();
    check("tick_59", pk(2,3,5,9,5,8,1,0,1));
    step();
    check("at_235959", pk(2,3,5,9,5,9,0,0,1));
    step(); step(); step();
    check("tick_wrap", pk(2,3,5,9,5,9,1,0,1));
    step();
    check("day_wrap", pk(0,0,0,0,0,0,0,1,1));
    step();
    check("day_wrap_end", pk(0,0,0,0,0,0,0,0,1));

    // RUN at 00:00:37: hours_inc ignored, SET clears seconds, prescaler restarts
    do_reset();
    run_ticks(37);
    check("at_000037", pk(0,0,0,0,3,7,0,0,1));
    bus.hours_inc = 1'b1;
    step();
    bus.hours_inc = 1'b0;
    check("run_hours_ignored", pk(0,0,0,0,3,7,0,0,1));
    bus.secs = 1'b0;
    step();
    check("mode_set", pk(0,0,0,0,3,7,0,0,0));
    step();
    check("secs_cleared", pk(0,0,0,0,0,0,0,0,0));
    bus.secs = 1'b1;
    step();
    check("rerun_mode", pk(0,0,0,0,0,0,0,0,1));
    step(); step();
    check("no_early_tick", pk(0,0,0,0,0,0,0,0,1));
    step();
    check("first_tick", pk(0,0,0,0,0,0,1,0,1));
    step();
    check("first_second", pk(0,0,0,0,0,1,0,0,1));

    // Reset coincident with a tick at 12:34:56
    do_reset();
    set_hm(12, 34);
    check("preload_1234", pk(1,2,3,4,0,0,0,0,0));
    run_ticks(56);
    check("at_123456", pk(1,2,3,4,5,6,0,0,1));
    step(); step(); step();
    check("tick_before_reset", pk(1,2,3,4,5,6,1,0,1));
    reset = 1'b1;
    step();
    check("reset_on_tick", pk(0,0,0,0,0,0,0,0,0));
    reset = 1'b0;
    bus.secs = 1'b0;
    step();
    check("after_reset", pk(0,0,0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
